sub_rr_arbiter: RTL and testbench

- Shares one signed subtractor between NREQ requesters.
- Each requester presents an (A, B) operand pair with a valid/ready handshake.
- A round-robin arbiter grants one request per cycle. The block computes A-B with a signed-overflow flag and returns the result, tagged with the requester ID, through a registered valid/ready output slot.
- Sits between the per-lane operand sources and the result collector in the 16-bit signed arithmetic path.

---
 rtl/sub_arb_pkg.sv | 29 ++
 rtl/sub_signed_core.sv | 24 ++
 rtl/sub_rr_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_sub_rr_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_arb_pkg.sv
// sub_arb_pkg: shared types and helpers for the shared signed subtractor
// arbiter (sub_rr_arbiter) and its arithmetic core (sub_signed_core).
//   slot_state_t  - output slot state (ST_EMPTY / ST_FULL)
//   DEFAULT_WIDTH - default operand/result width
//   clog2_safe()  - index width for a requester count, never below 1
package sub_arb_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

  localparam int DEFAULT_WIDTH = 16;

  // Smallest r >= 1 with 2**r >= n, so a 2-requester arbiter still gets a 1-bit id.
  function automatic int clog2_safe(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sub_signed_core.sv
// sub_signed_core: combinational two's complement subtractor with signed
// overflow detection.
//   a, b  in  WIDTH  minuend, subtrahend
//   diff  out WIDTH  a - b, wrapped modulo 2**WIDTH
//   ovf   out 1      signed overflow of a - b
module sub_signed_core
  import sub_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             ovf
);

  // a + (~b + 1): the most-negative b needs no special casing this way.
  assign diff = a + (~b) + WIDTH'(1);

  // Overflow only possible when the operand signs differ; it shows as a
  // result whose sign disagrees with the minuend.
  assign ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/sub_rr_arbiter.sv
// sub_rr_arbiter: round-robin arbitration of NREQ operand requesters onto one
// shared signed subtractor, with a registered valid/ready result slot.
//   clk, rst      clock, async active-high reset
//   req_valid/req_ready/req_a/req_b   per-requester request handshake
//   rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_overflow   result slot
//   ovf_count     saturating count of overflowing results accepted downstream
//   busy          slot full and stalled by downstream
module sub_rr_arbiter
  import sub_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNTW  = 16,
  localparam int IDW  = clog2_safe(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_overflow,
  output logic [CNTW-1:0]       ovf_count,
  output logic                  busy
);

  slot_state_t      state_r;
  slot_state_t      state_next_s;
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   ptr_next_s;
  logic [IDW-1:0]   grant_id_s;
  logic [IDW-1:0]   scan_idx_s;
  logic             found_s;
  logic             grant_s;
  logic             can_load_s;
  logic             out_hs_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic [WIDTH-1:0] diff_s;
  logic             ovf_s;
  logic [IDW-1:0]   rsp_id_r;
  logic [WIDTH-1:0] rsp_result_r;
  logic             rsp_overflow_r;
  logic [CNTW-1:0]  ovf_count_r;
  int               scan_v;

  // A full slot may refill in the same cycle it drains.
  assign can_load_s = (state_r == ST_EMPTY) || rsp_ready;
  assign grant_s    = can_load_s && found_s;
  assign out_hs_s   = (state_r == ST_FULL) && rsp_ready;

  // Round-robin scan: first valid requester at or above the pointer, wrapping.
  always_comb begin
    found_s    = 1'b0;
    grant_id_s = IDW'(0);
    scan_v     = 0;
    scan_idx_s = IDW'(0);
    for (int k = 0; k < NREQ; k++) begin
      scan_v = int'(ptr_r) + k;
      if (scan_v >= NREQ) begin
        scan_v = scan_v - NREQ;
      end else begin
        scan_v = scan_v;
      end
      scan_idx_s = scan_v[IDW-1:0];
      if (!found_s && req_valid[scan_idx_s]) begin
        found_s    = 1'b1;
        grant_id_s = scan_idx_s;
      end else begin
        found_s    = found_s;
      end
    end
  end

  // One-hot accept toward the granted requester; operand values never gate it.
  always_comb begin
    req_ready = {NREQ{1'b0}};
    if (grant_s) begin
      req_ready[grant_id_s] = 1'b1;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a_s = {WIDTH{1'b0}};
    sel_b_s = {WIDTH{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      if (grant_id_s == IDW'(k)) begin
        sel_a_s = req_a[k*WIDTH +: WIDTH];
        sel_b_s = req_b[k*WIDTH +: WIDTH];
      end else begin
        sel_a_s = sel_a_s;
      end
    end
  end

  sub_signed_core #(.WIDTH(WIDTH)) u_core (
    .a    (sel_a_s),
    .b    (sel_b_s),
    .diff (diff_s),
    .ovf  (ovf_s)
  );

  // Pointer advances past the granted requester.
  always_comb begin
    ptr_next_s = ptr_r;
    if (grant_id_s == IDW'(NREQ - 1)) begin
      ptr_next_s = IDW'(0);
    end else begin
      ptr_next_s = grant_id_s + IDW'(1);
    end
  end

  // Slot FSM next-state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (grant_s) begin
          state_next_s = ST_FULL;
        end else begin
          state_next_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (rsp_ready && !grant_s) begin
          state_next_s = ST_EMPTY;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      default: state_next_s = ST_EMPTY;
    endcase
  end

  // Slot state, pointer and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_EMPTY;
      ptr_r          <= IDW'(0);
      rsp_id_r       <= IDW'(0);
      rsp_result_r   <= {WIDTH{1'b0}};
      rsp_overflow_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (grant_s) begin
        ptr_r          <= ptr_next_s;
        rsp_id_r       <= grant_id_s;
        rsp_result_r   <= diff_s;
        rsp_overflow_r <= ovf_s;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  // Saturating count of overflowing results taken by downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count_r <= {CNTW{1'b0}};
    end else if (out_hs_s && rsp_overflow_r && (ovf_count_r != {CNTW{1'b1}})) begin
      ovf_count_r <= ovf_count_r + CNTW'(1);
    end else begin
      ovf_count_r <= ovf_count_r;
    end
  end

  assign rsp_valid    = (state_r == ST_FULL);
  assign rsp_id       = rsp_id_r;
  assign rsp_result   = rsp_result_r;
  assign rsp_overflow = rsp_overflow_r;
  assign ovf_count    = ovf_count_r;
  assign busy         = rsp_valid & ~rsp_ready;

endmodule

// File: tb/tb_sub_rr_arbiter.sv
// tb_sub_rr_arbiter: directed scoreboard bench for sub_rr_arbiter
// (NREQ=4, WIDTH=16, CNTW=2 so counter saturation is reachable).
module tb_sub_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int CNTW  = 2;
  localparam int IDW   = 2;

  typedef struct {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] res;
    logic             ovf;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_overflow;
  logic [CNTW-1:0]       ovf_count;
  logic                  busy;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  sub_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .ovf_count    (ovf_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic push(input int id, input logic [WIDTH-1:0] res, input logic ovf);
    exp_t e;
    e.id  = IDW'(id);
    e.res = res;
    e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] t2_res[5];
    logic [NREQ-1:0]  onehot;
    t2_res[0] = 16'hFFFF;  // 0 - 1
    t2_res[1] = 16'd99;
    t2_res[2] = 16'd199;
    t2_res[3] = 16'd299;
    t2_res[4] = 16'hFFFF;

    rst       = 1'b1;
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // Output-side monitor: pops the scoreboard on every result handshake.
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got id %0d result %0h, none expected", rsp_id, rsp_result);
          end else begin
            e = exp_q.pop_front();
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_result", 32'(rsp_result), 32'(e.res));
            check("rsp_overflow", 32'(rsp_overflow), 32'(e.ovf));
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_result", 32'(rsp_result), 32'd0);
    check("rst_ovf", 32'(rsp_overflow), 32'd0);
    check("rst_count", 32'(ovf_count), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Test 1: single overflowing request, one-cycle latency
    rsp_ready = 1'b1;
    set_req(0, 16'h7FFF, 16'hFFFF);
    req_valid = 4'b0001;
    #3 check("t1_ready", 32'(req_ready), 32'h1);
    push(0, 16'h8000, 1'b1);
    tick();
    req_valid = 4'b0000;
    #3 check("t1_valid", 32'(rsp_valid), 32'd1);
    tick();
    check("t1_count", 32'(ovf_count), 32'd1);
    check("t1_empty", 32'(rsp_valid), 32'd0);

    // Test 2: all four requesters from reset, grants 0,1,2,3,0 back to back
    reset_pulse();
    for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(100 * i), 16'd1);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      onehot = 4'b0001 << (k % 4);
      #3 check("t2_ready", 32'(req_ready), 32'(onehot));
      push(k % 4, t2_res[k], 1'b0);
      tick();
    end
    req_valid = 4'b0000;
    tick();
    check("t2_count", 32'(ovf_count), 32'd0);

    // Test 3: stalled slot holds while requester 2 waits
    rsp_ready = 1'b0;
    set_req(2, 16'h8000, 16'h0001);
    req_valid = 4'b0100;
    #3 check("t3_grant", 32'(req_ready), 32'h4);
    push(2, 16'h7FFF, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      #3;
      check("t3_stall_ready", 32'(req_ready), 32'h0);
      check("t3_busy", 32'(busy), 32'd1);
      check("t3_hold_result", 32'(rsp_result), 32'h7FFF);
      check("t3_hold_ovf", 32'(rsp_overflow), 32'd1);
      check("t3_hold_id", 32'(rsp_id), 32'd2);
      tick();
    end
    check("t3_count_stalled", 32'(ovf_count), 32'd0);
    rsp_ready = 1'b1;
    #3 check("t3_refill", 32'(req_ready), 32'h4);
    push(2, 16'h7FFF, 1'b1);
    tick();
    check("t3_count_once", 32'(ovf_count), 32'd1);

    // Test 4: drain and refill in the same cycle, no bubble
    set_req(1, 16'hC000, 16'h4000);
    req_valid = 4'b0010;
    #3 check("t4_ready", 32'(req_ready), 32'h2);
    push(1, 16'h8000, 1'b0);
    tick();
    req_valid = 4'b0000;
    #3;
    check("t4_valid", 32'(rsp_valid), 32'd1);
    check("t4_id", 32'(rsp_id), 32'd1);
    check("t4_result", 32'(rsp_result), 32'h8000);
    check("t4_count", 32'(ovf_count), 32'd2);
    tick();
    check("t4_empty", 32'(rsp_valid), 32'd0);

    // Test 5: asynchronous reset with a full slot, then pointer back at 0
    rsp_ready = 1'b0;
    set_req(3, 16'd5, 16'd3);
    req_valid = 4'b1000;
    #3 check("t5_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0000;
    check("t5_full", 32'(rsp_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(rsp_valid), 32'd0);
    check("t5_rst_count", 32'(ovf_count), 32'd0);
    check("t5_rst_result", 32'(rsp_result), 32'd0);
    tick();
    rst = 1'b0;
    set_req(3, 16'd10, 16'd3);
    set_req(0, 16'd7, 16'd9);
    req_valid = 4'b1001;
    rsp_ready = 1'b1;
    #3 check("t5_first", 32'(req_ready), 32'h1);
    push(0, 16'hFFFE, 1'b0);
    tick();
    #3 check("t5_second", 32'(req_ready), 32'h8);
    push(3, 16'd7, 1'b0);
    tick();
    req_valid = 4'b0000;
    tick();

    // Test 6: five overflowing results saturate the 2-bit counter at 3
    set_req(0, 16'h7FFF, 16'hFFFF);
    set_req(1, 16'h0000, 16'h8000);
    req_valid = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      onehot = ((k % 2) == 0) ? 4'b0001 : 4'b0010;
      #3 check("t6_ready", 32'(req_ready), 32'(onehot));
      push(k % 2, 16'h8000, 1'b1);
      tick();
    end
    req_valid = 4'b0000;
    tick();
    check("t6_count_sat", 32'(ovf_count), 32'd3);

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
